// File: rtl/opgrp_credit_sched_pkg.sv
// opgrp_credit_sched_pkg: arbiter state encoding and credit counter width helper.
package opgrp_credit_sched_pkg;
  typedef enum logic [1:0] {ARB, HOLD, LOCK} arb_state_e;
  function automatic int credit_width(input int max_outstanding);
    return $clog2(max_outstanding + 1);
  endfunction
endpackage

// File: rtl/opgrp_credit_counter.sv
// opgrp_credit_counter: up/down occupancy counter bounded at MaxOutstanding, floored at 0.
module opgrp_credit_counter
  import opgrp_credit_sched_pkg::*;
#(
  parameter int MaxOutstanding = 4,
  parameter int Width = credit_width(MaxOutstanding)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [Width-1:0] cnt_o,
  output logic             full_o
);
  logic [Width-1:0] cnt_q, cnt_d;
  assign full_o = cnt_q == Width'(MaxOutstanding);
  assign cnt_o = cnt_q;
  // A spurious decrement at zero saturates instead of wrapping.
  assign cnt_d = (inc_i && !dec_i && !full_o) ? cnt_q + 1'b1 :
                 (dec_i && !inc_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/opgrp_credit_sched.sv
// opgrp_credit_sched: credit-bounded dispatch to opgroups and lockable round-robin result arbiter.
// Define OPGRP_CREDIT_SCHED_LOCK_TIMEOUT_EN to force-release an idle lock after LockTimeout cycles.
module opgrp_credit_sched
  import opgrp_credit_sched_pkg::*;
#(
  parameter int NumOpgroups = 3,
  parameter int OpWidth = $clog2(NumOpgroups),
  parameter int DataWidth = 8,
  parameter int IDSize = 5,
  parameter int MaxOutstanding = 4,
  parameter int LockTimeout = 5,
  localparam int CW = credit_width(MaxOutstanding)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             enable_i,
  input  logic [DataWidth-1:0]             in_data_i,
  input  logic [OpWidth-1:0]               in_op_i,
  input  logic [IDSize-1:0]                in_id_i,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  output logic [DataWidth-1:0]             opgrp_data_o,
  output logic [IDSize-1:0]                opgrp_id_o,
  output logic [NumOpgroups-1:0]           opgrp_valid_o,
  input  logic [NumOpgroups-1:0]           opgrp_ready_i,
  input  logic [NumOpgroups*DataWidth-1:0] res_data_i,
  input  logic [NumOpgroups*IDSize-1:0]    res_id_i,
  input  logic [NumOpgroups-1:0]           res_valid_i,
  output logic [NumOpgroups-1:0]           res_ready_o,
  output logic [DataWidth-1:0]             out_data_o,
  output logic [IDSize-1:0]                out_id_o,
  output logic [OpWidth-1:0]               out_op_o,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  input  logic                             lock_i,
  output logic [NumOpgroups*CW-1:0]        credit_o,
  output logic                             illegal_op_o,
  output logic                             lock_timeout_o
);
  localparam logic [OpWidth:0] NumOps = NumOpgroups[OpWidth:0];
  localparam logic [OpWidth-1:0] LastIdx = OpWidth'(NumOpgroups - 1);

  if (NumOpgroups < 2 || MaxOutstanding < 1 || LockTimeout < 1) begin : g_param_check
    $error("opgrp_credit_sched: invalid parameters");
  end

  arb_state_e state_q, state_d;
  logic [OpWidth-1:0] ptr_q, ptr_d, grant_q, grant, sel, idx, next_ptr;
  logic [NumOpgroups-1:0] full, disp_hs, res_hs;
  logic [DataWidth-1:0] res_data [NumOpgroups];
  logic [IDSize-1:0] res_id [NumOpgroups];
  logic legal, hs, timeout;

  assign legal = {1'b0, in_op_i} < NumOps;
  assign in_ready_o = legal ? opgrp_ready_i[in_op_i] & ~full[in_op_i] : 1'b1;
  assign illegal_op_o = in_valid_i & ~legal;
  assign opgrp_data_o = in_valid_i ? in_data_i : '0;
  assign opgrp_id_o = in_valid_i ? in_id_i : '0;
  assign disp_hs = opgrp_valid_o & opgrp_ready_i;
  assign res_hs = res_valid_i & res_ready_o;

  for (genvar g = 0; g < NumOpgroups; g++) begin : g_opgrp
    assign opgrp_valid_o[g] = in_valid_i & legal & (in_op_i == OpWidth'(g)) & ~full[g];
    assign res_ready_o[g] = hs & (grant == OpWidth'(g));
    assign res_data[g] = res_data_i[g*DataWidth +: DataWidth];
    assign res_id[g] = res_id_i[g*IDSize +: IDSize];
    opgrp_credit_counter #(
      .MaxOutstanding(MaxOutstanding),
      .Width(CW)
    ) u_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (disp_hs[g]),
      .dec_i (res_hs[g]),
      .cnt_o (credit_o[g*CW +: CW]),
      .full_o(full[g])
    );
  end

  // Scan from the highest offset down so the nearest valid index at or after ptr wins.
  always_comb begin
    sel = ptr_q;
    idx = '0;
    for (int k = NumOpgroups - 1; k >= 0; k--) begin
      idx = OpWidth'((int'(ptr_q) + k) % NumOpgroups);
      if (res_valid_i[idx]) sel = idx;
    end
  end

  assign grant = state_q == ARB ? sel : grant_q;
  assign out_valid_o = res_valid_i[grant];
  assign hs = out_valid_o & out_ready_i;
  assign next_ptr = grant == LastIdx ? '0 : grant + 1'b1;

`ifdef OPGRP_CREDIT_SCHED_LOCK_TIMEOUT_EN
  localparam int IW = $clog2(LockTimeout + 1);
  logic [IW-1:0] idle_q, idle_d;
  assign timeout = state_q == LOCK && !out_valid_o && idle_q == IW'(LockTimeout - 1);
  assign idle_d = (state_q == LOCK && !out_valid_o) ? idle_q + 1'b1 : '0;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) idle_q <= '0;
    else idle_q <= idle_d;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q <= ARB;
      ptr_q <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      grant_q <= grant;
    end

  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    if (state_q == LOCK) begin
      state_d = (!lock_i || !enable_i || timeout) ? ARB : LOCK;
      ptr_d = (!lock_i || !enable_i || timeout) ? next_ptr : ptr_q;
    end else if (hs) begin
      state_d = (lock_i && enable_i) ? LOCK : ARB;
      ptr_d = (lock_i && enable_i) ? ptr_q : next_ptr;
    end else begin
      state_d = out_valid_o ? HOLD : ARB;
    end
  end

  always_comb begin
    out_data_o = out_valid_o ? res_data[grant] : '0;
    out_id_o = out_valid_o ? res_id[grant] : '0;
    out_op_o = out_valid_o ? grant : '0;
    lock_timeout_o = timeout;
  end
endmodule

// File: tb/tb_opgrp_credit_sched.sv
// tb_opgrp_credit_sched: directed vectors for dispatch credits, illegal ops, round-robin, lock and hold.
module tb_opgrp_credit_sched;
  logic clk_i = 1'b0;
  logic rst_i, enable_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i, lock_i;
  logic illegal_op_o, lock_timeout_o;
  logic [7:0] in_data_i, opgrp_data_o, out_data_o;
  logic [1:0] in_op_i, out_op_o;
  logic [4:0] in_id_i, opgrp_id_o, out_id_o;
  logic [2:0] opgrp_valid_o, opgrp_ready_i, res_valid_i, res_ready_o;
  logic [23:0] res_data_i;
  logic [14:0] res_id_i;
  logic [8:0] credit_o;
  int vectors = 0, miscompares = 0;

  opgrp_credit_sched dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i),
    .in_data_i(in_data_i), .in_op_i(in_op_i), .in_id_i(in_id_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .opgrp_data_o(opgrp_data_o), .opgrp_id_o(opgrp_id_o),
    .opgrp_valid_o(opgrp_valid_o), .opgrp_ready_i(opgrp_ready_i),
    .res_data_i(res_data_i), .res_id_i(res_id_i),
    .res_valid_i(res_valid_i), .res_ready_o(res_ready_o),
    .out_data_o(out_data_o), .out_id_o(out_id_o), .out_op_o(out_op_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .lock_i(lock_i),
    .credit_o(credit_o), .illegal_op_o(illegal_op_o), .lock_timeout_o(lock_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [2:0] cred(input int g);
    return credit_o[g*3 +: 3];
  endfunction

  initial begin
    logic [1:0] rr_op [4];
    logic [7:0] rr_data [3];
    rr_op = '{2'd0, 2'd1, 2'd2, 2'd0};
    rr_data = '{8'hA0, 8'hB1, 8'hC2};
    rst_i = 1; enable_i = 1; in_valid_i = 0; in_op_i = 0; in_data_i = 0; in_id_i = 0;
    opgrp_ready_i = 0; res_valid_i = 0; res_data_i = 0; res_id_i = 0; out_ready_i = 0; lock_i = 0;
    @(negedge clk_i);
    chk("rst_credit", credit_o, 0);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_out_data", out_data_o, 0);
    chk("rst_in_ready", in_ready_o, 0);
    chk("rst_pulses", {illegal_op_o, lock_timeout_o}, 0);
    chk("rst_dispatch", opgrp_valid_o, 0);
    chk("rst_res_ready", res_ready_o, 0);
    tick();
    rst_i = 0;
    // five beats to op 1: the fifth meets a full credit counter
    opgrp_ready_i = 3'b111; in_valid_i = 1; in_op_i = 1;
    for (int i = 0; i < 5; i++) begin
      in_data_i = 8'(16 + i); in_id_i = 5'(i);
      @(negedge clk_i);
      chk($sformatf("disp%0d_ready", i), in_ready_o, i < 4);
      chk($sformatf("disp%0d_valid", i), opgrp_valid_o, i < 4 ? 3'b010 : 3'b000);
      chk($sformatf("disp%0d_data", i), {opgrp_id_o, opgrp_data_o}, {5'(i), 8'(16 + i)});
      chk($sformatf("disp%0d_credit", i), cred(1), i);
      tick();
    end
    in_valid_i = 0;
    @(negedge clk_i);
    chk("credit1_full", cred(1), 4);
    tick();
    // two beats to op 0, then a simultaneous dispatch and result
    in_valid_i = 1; in_op_i = 0;
    @(negedge clk_i);
    chk("op0_ready", in_ready_o, 1);
    tick();
    @(negedge clk_i);
    chk("op0_credit1", cred(0), 1);
    tick();
    res_valid_i = 3'b001; res_data_i = 24'h0000AA; res_id_i = 15'h0003; out_ready_i = 1;
    @(negedge clk_i);
    chk("same_res_ready", res_ready_o, 3'b001);
    chk("same_disp_valid", opgrp_valid_o, 3'b001);
    chk("same_out", {out_valid_o, out_op_o, out_id_o, out_data_o}, {1'b1, 2'd0, 5'd3, 8'hAA});
    tick();
    in_valid_i = 0; res_valid_i = 0; out_ready_i = 0;
    @(negedge clk_i);
    chk("same_credit0", cred(0), 2);
    tick();
    in_valid_i = 1; in_op_i = 3;
    @(negedge clk_i);
    chk("illegal_ready", in_ready_o, 1);
    chk("illegal_pulse", illegal_op_o, 1);
    chk("illegal_no_dispatch", opgrp_valid_o, 0);
    tick();
    in_valid_i = 0;
    @(negedge clk_i);
    chk("illegal_pulse_end", illegal_op_o, 0);
    chk("illegal_credits", credit_o, 9'b000_100_010);
    tick();
    rst_i = 1;
    @(negedge clk_i);
    chk("mid_rst_credit", credit_o, 0);
    tick();
    rst_i = 0;
    // round robin over three valid results; results with zero credit must not underflow
    res_valid_i = 3'b111; res_data_i = {rr_data[2], rr_data[1], rr_data[0]};
    res_id_i = {5'd7, 5'd6, 5'd5}; out_ready_i = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk($sformatf("rr%0d_op", i), out_op_o, rr_op[i]);
      chk($sformatf("rr%0d_data", i), {out_id_o, out_data_o}, {5'(5 + rr_op[i]), rr_data[rr_op[i]]});
      chk($sformatf("rr%0d_ready", i), res_ready_o, 3'b001 << rr_op[i]);
      tick();
    end
    res_valid_i = 0;
    @(negedge clk_i);
    chk("rr_no_underflow", credit_o, 0);
    tick();
    // lock on index 2, then only index 0 requests
    res_valid_i = 3'b100; lock_i = 1;
    @(negedge clk_i);
    chk("lock_grant", {out_op_o, res_ready_o}, {2'd2, 3'b100});
    tick();
    res_valid_i = 3'b001;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk_i);
      chk($sformatf("lock_idle%0d_ready", i), res_ready_o, 0);
`ifdef OPGRP_CREDIT_SCHED_LOCK_TIMEOUT_EN
      chk($sformatf("lock_idle%0d_timeout", i), lock_timeout_o, i == 5);
`else
      chk($sformatf("lock_idle%0d_timeout", i), lock_timeout_o, 0);
`endif
      tick();
    end
    lock_i = 0;
`ifndef OPGRP_CREDIT_SCHED_LOCK_TIMEOUT_EN
    @(negedge clk_i);
    chk("lock_release_ready", res_ready_o, 0);
    tick();
`endif
    @(negedge clk_i);
    chk("after_lock_grant", {out_op_o, res_ready_o}, {2'd0, 3'b001});
    tick();
    res_valid_i = 3'b010;
    @(negedge clk_i);
    chk("pre_hold_grant", out_op_o, 1);
    tick();
    // hold on index 1 with pointer at 2; index 0 would win if the grant moved
    out_ready_i = 0; res_data_i = {8'h00, 8'h55, 8'h66};
    for (int i = 0; i < 3; i++) begin
      if (i == 1) res_valid_i = 3'b011;
      @(negedge clk_i);
      chk($sformatf("hold%0d_out", i), {out_valid_o, out_op_o, out_data_o}, {1'b1, 2'd1, 8'h55});
      chk($sformatf("hold%0d_ready", i), res_ready_o, 0);
      tick();
    end
    out_ready_i = 1;
    @(negedge clk_i);
    chk("hold_accept", {out_op_o, out_data_o, res_ready_o}, {2'd1, 8'h55, 3'b010});
    tick();
    res_valid_i = 3'b001; lock_i = 1; enable_i = 0;
    @(negedge clk_i);
    chk("post_hold_grant", {out_op_o, out_data_o}, {2'd0, 8'h66});
    tick();
    res_valid_i = 3'b011;
    @(negedge clk_i);
    chk("enable_off_no_lock", out_op_o, 1);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
